// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock via a W+1-bit trial subtract.
// Latency W+1 cycles start-to-done (1 cycle for a zero divisor when SEQ_DIVIDER_ZERO_CHECK_EN is defined).
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is ignored.
module seq_divider #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder,
  output logic         o_div_by_zero
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  // Partial remainder never reaches 2**W (it stays below the divisor),
  // so only the shifted trial value needs the extra bit.
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_div;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_quot_out;
  logic [W-1:0]   r_rem_out;

  logic           w_accept;
  logic           w_zero_div;
  logic           w_last;
  logic [W:0]     w_shift;
  logic [W:0]     w_trial;
  logic           w_fit;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_q_next;

  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == '0);

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign w_zero_div = (i_divisor == '0);
`else
  assign w_zero_div = 1'b0;
`endif

  // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep or restore.
  always_comb begin
    w_shift    = {r_rem, r_q[W-1]};
    w_trial    = w_shift - {1'b0, r_div};
    w_fit      = ~w_trial[W];
    w_rem_next = w_fit ? w_trial[W-1:0] : w_shift[W-1:0];
    w_q_next   = {r_q[W-2:0], w_fit};
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        o_done = (r_state == S_DONE);
        if (w_accept) w_next_state = w_zero_div ? S_DONE : S_RUN;
        else          w_next_state = S_IDLE;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == '0) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Working registers: load on accepted start, iterate while running.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem <= '0;
      r_q   <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_q   <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= CW'(W - 1);
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Result registers: written only on the edge entering DONE, held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_quot_out <= '0;
      r_rem_out  <= '0;
    end else if (w_accept && w_zero_div) begin
      r_quot_out <= '1;
      r_rem_out  <= i_dividend;
    end else if (w_last) begin
      r_quot_out <= w_q_next;
      r_rem_out  <= w_rem_next;
    end
  end

  assign o_quotient  = r_quot_out;
  assign o_remainder = r_rem_out;

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic r_dbz;

  // Zero-divisor flag travels with the results it describes.
  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_dbz <= 1'b0;
    else if (w_accept && w_zero_div) r_dbz <= 1'b1;
    else if (w_last)                r_dbz <= 1'b0;
  end

  assign o_div_by_zero = r_dbz;
`else
  assign o_div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed boundary cases plus randomized operands.
// Expected quotient/remainder come from plain / and % in a reference function.
// Latency is measured in edges from the accepting edge until done is seen.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(.W(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_busy       (busy),
    .o_done       (done),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what a divide of a by b must produce and how long it takes.
  function automatic void ref_div(input int a, input int b,
                                  output int eq, output int er,
                                  output int elat, output int edbz);
    if (b == 0) begin
      eq = (1 << W) - 1;
      er = a;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      elat = 1;
      edbz = 1;
`else
      elat = W + 1;
      edbz = 0;
`endif
    end else begin
      eq   = a / b;
      er   = a % b;
      elat = W + 1;
      edbz = 0;
    end
  endfunction

  // Called right after the accepting edge; returns once done is seen or the budget runs out.
  task automatic wait_done(input string tag, input int exp_lat, output int nbusy);
    int lat;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 4 * W) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input bit full);
    int eq, er, elat, edbz, nb;
    ref_div(a, b, eq, er, elat, edbz);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    wait_done(tag, elat, nb);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dbz"}, div_by_zero, edbz);
    if (b != 0) begin
      chk({tag, ".ident"}, int'(quotient) * b + int'(remainder), a);
      chk({tag, ".r_lt_d"}, int'(remainder) < b, 1);
    end
    if (full) begin
      chk({tag, ".busy_cycles"}, nb, elat - 1);
      tick();
      chk({tag, ".done_pulse"}, done, 0);
      chk({tag, ".q_held"}, quotient, eq);
      chk({tag, ".r_held"}, remainder, er);
    end
  endtask

  initial begin
    int nb;
    int ndone;
    int a;
    int b;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.q", quotient, 0);
    chk("rst.r", remainder, 0);
    chk("rst.dbz", div_by_zero, 0);
    rst = 1'b0;
    tick();

    run_op("d100_7", 100, 7, 1);
    chk("d100_7.q_const", quotient, 14);
    chk("d100_7.r_const", remainder, 2);
    run_op("d255_1", 255, 1, 1);
    run_op("d5_10", 5, 10, 1);
    run_op("d255_255", 255, 255, 1);
    run_op("d0_3", 0, 3, 1);
    run_op("d37_0", 37, 0, 1);

    // start held through RUN with the operands changing underneath
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd9;
    tick();
    dividend = 8'd50;
    divisor  = 8'd5;
    wait_done("hold1", W + 1, nb);
    chk("hold1.q", quotient, 22);
    chk("hold1.r", remainder, 2);
    chk("hold1.busy_cycles", nb, W);
    tick();
    start = 1'b0;
    chk("hold2.busy_after_restart", busy, 1);
    chk("hold2.q_kept", quotient, 22);
    wait_done("hold2", W + 1, nb);
    chk("hold2.q", quotient, 10);
    chk("hold2.r", remainder, 0);
    tick();

    // reset in the fourth RUN cycle of 200/9
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd9;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid.busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.q", quotient, 0);
    chk("mid.r", remainder, 0);
    chk("mid.dbz", div_by_zero, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("mid.no_done", ndone, 0);
    run_op("d13_4", 13, 4, 1);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(1, (1 << W) - 1));
      run_op("rnd", a, b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Unsigned sequential restoring divider; the inverse-arithmetic companion to the datapath's carry-lookahead adders. Computes quotient and remainder of a W-bit dividend by a W-bit divisor, one quotient bit per clock, using a single W+1-bit trial subtractor. Sits beside the ALU as a multi-cycle execution unit with a start/done handshake.

## Interface
- W, 8, operand width in bits; legal range 2..32.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is ready to accept (IDLE or DONE).
- dividend  in  W  unsigned dividend; captured on accepted start.
- divisor  in  W  unsigned divisor; captured on accepted start.
- busy  out  1  high while iterating (RUN).
- done  out  1  one-cycle pulse; results valid.
- quotient  out  W  result quotient; held until next accepted start.
- remainder  out  W  result remainder; held until next accepted start.
- div_by_zero  out  1  high with done when captured divisor was 0; held with results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 -> capture operands, clear remainder accumulator R (W+1 bits), load quotient shift register Q with dividend, iteration counter = W-1, go RUN.
- RUN, each cycle: shift {R,Q} left by one (Q MSB into R LSB); T = R_shifted - {1'b0,divisor} in W+1 bits; if T MSB == 0 then R = T, Q LSB = 1, else R = R_shifted, Q LSB = 0. Counter decrements; after the cycle with counter == 0 go DONE.
- DONE: done=1, busy=0, quotient = Q, remainder = R[W-1:0]. start=1 in DONE is accepted exactly as in IDLE (back-to-back, next state RUN); else go IDLE.
- start while in RUN: ignored, no effect on operands or count.
- Operand inputs are don't-care except in the accepting cycle.
- Divisor 0 (unchecked path): every trial succeeds -> quotient = all ones, remainder = dividend.
- rst in any state: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0; in-flight operation discarded, no done issued.

## Timing
- Reset values: all outputs 0.
- start accepted at edge k -> busy high cycles k+1..k+W; done high exactly in cycle k+W+1; latency W+1 cycles start-to-done.
- quotient/remainder/div_by_zero update at the edge entering DONE and are stable from then until the edge following the next accepted start... they are not cleared on leaving DONE.
- Throughput with back-to-back starts: one result per W+1 cycles.
- rst has priority over start on the same edge.

## Configuration
- Macro SEQ_DIVIDER_ZERO_CHECK_EN.
- Defined: on accepted start with divisor == 0, skip RUN; go directly to DONE next cycle (done at k+1), quotient = all ones, remainder = dividend, div_by_zero = 1. Nonzero divisor: div_by_zero = 0, normal timing.
- Not defined: no zero check; divisor 0 runs full W cycles and yields quotient all ones, remainder = dividend by the arithmetic; div_by_zero tied 0.

## Test plan
- W=8, dividend 100, divisor 7, start pulse -> busy 8 cycles, done in cycle 9 after start, quotient 14, remainder 2, div_by_zero 0.
- Boundaries: 255/1 -> q 255 r 0; 5/10 -> q 0 r 5; 255/255 -> q 1 r 0; 0/3 -> q 0 r 0.
- Divisor 0, dividend 37: with macro -> done at k+1, q 255, r 37, div_by_zero 1; without -> done at k+9, q 255, r 37, div_by_zero 0.
- start held high through RUN with changing operands (200/9 accepted, then 50/5 presented) -> single result q 22 r 2; start still high in DONE starts 50/5 -> q 10 r 0 nine cycles later.
- rst asserted mid-RUN (cycle 4 of 200/9) -> next cycle all outputs 0, state IDLE, no done pulse; fresh 13/4 afterwards -> q 3 r 1.
- Randomized 1000 operand pairs (nonzero divisor) vs. reference model -> dividend == q*divisor + r, r < divisor, exact latency 9.
